riscv_intc_plic: RTL and testbench
==================================

Name: riscv_intc_plic

Overview:
Parametrised successor interrupt controller for the RISC-V core: NUMINT external sources, each with enable, level/edge mode and a priority level. A global threshold, claim/complete handshake and input synchronisers sit between the sources and the core. Synchronous exceptions (illegal instruction, misaligned access, ecall) keep combinational priority on cause_o. Sits between the platform interrupt lines and the core CSR/trap logic.

Parameters:
NUMINT, 16, number of external interrupt sources (2..64)
PRIO_W, 3, priority field width; priority 0 = never interrupts
MXLEN, 32, cause_o width
CAUSE_BASE, 32'h80000010, cause value for source 0; source i reports CAUSE_BASE+i

Ports:
clk_i  in  1  core clock
rstn_i  in  1  asynchronous active-low reset
ext_int_i  in  NUMINT  raw external interrupt lines, asynchronous to clk_i
en_i  in  NUMINT  per-source enable
edge_mode_i  in  NUMINT  1 = rising-edge triggered, 0 = level
prio_i  in  NUMINT*PRIO_W  per-source priority; source i at [i*PRIO_W +: PRIO_W]
threshold_i  in  PRIO_W  a source interrupts only if prio > threshold_i
global_en_i  in  1  global external interrupt enable (mstatus.MIE & mie.MEIE)
irq_o  out  1  interrupt request to core
cause_o  out  MXLEN  trap cause
claim_i  in  1  core takes the interrupt (single-cycle pulse)
complete_i  in  1  handler finished (single-cycle pulse)
active_o  out  1  a claimed interrupt is in service
illegal_instr_i  in  1  illegal instruction flag
misalig_acc_i  in  1  misaligned access flag
ecall_i  in  1  env call flag

Behaviour:
- Reset (async assert, sync release): synchronisers, pending, arbitration regs, active, claimed_id all 0. Resulting irq_o=0, active_o=0, cause_o=0 (absent exception inputs).
- Sync: 2-flop synchroniser per line, plus a 3rd flop for edge detection. rise[i] = s2[i] & ~s3[i].
- Pending, registered:
  - Edge source: pending set on rise & en_i; stays set until claimed.
  - Level source: pending <= s2 & en_i each cycle; it drops if the line drops before claim.
  - Set wins over claim-clear in the same cycle for the same source.
- Arbitration, registered (1 cycle):
  - Candidates: pending & en_i & prio > threshold_i.
  - Winner: highest prio; ties go to the lowest index.
  - Outputs: win_valid_q, win_id_q ($clog2(NUMINT) bits).
- irq_o = win_valid_q & global_en_i & ~active_q (combinational from regs).
- Latency: line high before edge 1 → pending at edge 3 → irq_o high after edge 4.
- Claim: claim_i while irq_o=1 sets active_q, claimed_id_q<=win_id_q, and clears pending[win_id_q] (edge sources). irq_o falls the next cycle. claim_i while irq_o=0 is ignored.
- Level source while active with the same id: excluded from candidates until complete; re-raises after complete if the line is still high.
- Complete: complete_i while active_q clears active_q. Ignored when inactive. Single outstanding claim, no preemption.
- cause_o priority (combinational):
  1. illegal 2
  2. misaligned 4
  3. ecall 11
  4. irq_o → CAUSE_BASE+win_id_q
  5. active_q → CAUSE_BASE+claimed_id_q
  6. otherwise 0
  Exceptions never affect irq_o or pending.
- global_en_i=0: pending and arbitration continue; only irq_o is masked.
- threshold_i/prio_i/en_i changes take effect on the next arbitration register update. A pending edge source disabled then re-enabled keeps its pending bit.
- Reset mid-service: active and all pending lost; edges latched before reset are dropped.

Test Plan:
- Edge source 5, prio 3, threshold 0: pulse ext_int_i[5] for 1 cycle → irq_o high 4 cycles later, cause_o=32'h80000015; claim → irq_o low next cycle, active_o=1; complete → active_o=0, no re-raise.
- Sources 2 (prio 4) and 7 (prio 6) both pending → cause_o=32'h80000017. After claim+complete of 7 → source 2 raises cause 32'h80000012. Equal prios on 3 and 9 → 3 wins.
- Threshold 4, source 1 prio 4 pending → irq_o=0. Threshold changed to 3 → irq_o high after 1 cycle.
- Level source 0 held high across claim/complete → re-raises 1 cycle after complete. Line dropped before claim → irq_o falls, no claim possible.
- Edge on source 4 while source 4 is active → pending retained, irq re-raised after complete. global_en_i=0 with pending → irq_o stays 0, asserts when enabled.
- illegal_instr_i with irq_o high → cause_o=2 while asserted, irq_o unchanged. rstn_i low mid-service → irq_o=0, active_o=0 immediately (asynchronous).

Source files
------------

// File: rtl/riscv_intc_plic.sv
// Interrupt controller with prioritised external sources, claim/complete handshake
// and combinational priority of synchronous exceptions on the trap cause.
module riscv_intc_plic #(
  parameter int                 NUMINT     = 16,
  parameter int                 PRIO_W     = 3,
  parameter int                 MXLEN      = 32,
  parameter logic [MXLEN-1:0]   CAUSE_BASE = 32'h80000010
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NUMINT-1:0]        ext_int_i,
  input  logic [NUMINT-1:0]        en_i,
  input  logic [NUMINT-1:0]        edge_mode_i,
  input  logic [NUMINT*PRIO_W-1:0] prio_i,
  input  logic [PRIO_W-1:0]        threshold_i,
  input  logic                     global_en_i,
  output logic                     irq_o,
  output logic [MXLEN-1:0]         cause_o,
  input  logic                     claim_i,
  input  logic                     complete_i,
  output logic                     active_o,
  input  logic                     illegal_instr_i,
  input  logic                     misalig_acc_i,
  input  logic                     ecall_i
);
  localparam int IDW = (NUMINT > 1) ? $clog2(NUMINT) : 1;

  logic [NUMINT-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUMINT-1:0] pending_q, pending_d;
  logic [NUMINT-1:0] rise, claimClr;
  logic              win_valid_q, win_valid_d;
  logic [IDW-1:0]    win_id_q, win_id_d, claimed_id_q;
  logic              active_q;
  logic              claimFire;
  logic [PRIO_W-1:0] curPrio, bestPrio;

  assign rise      = sync2_q & ~sync3_q;
  assign irq_o     = win_valid_q & global_en_i & ~active_q;
  assign claimFire = claim_i & irq_o;
  assign active_o  = active_q;

  // A new edge in the claim cycle keeps the bit set, so that interrupt is not lost.
  always_comb begin
    claimClr = '0;
    if (claimFire) claimClr[win_id_q] = 1'b1;
    pending_d = (edge_mode_i & ((pending_q & ~claimClr) | (rise & en_i)))
              | (~edge_mode_i & sync2_q & en_i);
  end

  // Strict '>' against the running best keeps the lowest index on equal priority;
  // the level source currently in service is held out until it is completed.
  always_comb begin
    win_valid_d = 1'b0;
    win_id_d    = '0;
    bestPrio    = '0;
    curPrio     = '0;
    for (int i = 0; i < NUMINT; i++) begin
      curPrio = prio_i[i*PRIO_W +: PRIO_W];
      if (pending_q[i] && en_i[i] && (curPrio > threshold_i)
          && !(active_q && !edge_mode_i[i] && (claimed_id_q == IDW'(i)))
          && (!win_valid_d || (curPrio > bestPrio))) begin
        win_valid_d = 1'b1;
        win_id_d    = IDW'(i);
        bestPrio    = curPrio;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      sync3_q      <= '0;
      pending_q    <= '0;
      win_valid_q  <= 1'b0;
      win_id_q     <= '0;
      active_q     <= 1'b0;
      claimed_id_q <= '0;
    end else begin
      sync1_q     <= ext_int_i;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      pending_q   <= pending_d;
      win_valid_q <= win_valid_d;
      win_id_q    <= win_id_d;
      if (claimFire) begin
        active_q     <= 1'b1;
        claimed_id_q <= win_id_q;
      end else if (complete_i && active_q) begin
        active_q <= 1'b0;
      end
    end
  end

  always_comb begin
    if (illegal_instr_i)    cause_o = MXLEN'(2);
    else if (misalig_acc_i) cause_o = MXLEN'(4);
    else if (ecall_i)       cause_o = MXLEN'(11);
    else if (irq_o)         cause_o = CAUSE_BASE + MXLEN'(win_id_q);
    else if (active_q)      cause_o = CAUSE_BASE + MXLEN'(claimed_id_q);
    else                    cause_o = '0;
  end

endmodule

// File: tb/tb_riscv_intc_plic.sv
// Self-checking bench for riscv_intc_plic: exception table, directed claim/complete
// sequences and randomized traffic against a delay-line/priority-scan reference model.
module tb_riscv_intc_plic;
  localparam int          N    = 16;
  localparam int          PW   = 3;
  localparam logic [31:0] BASE = 32'h80000010;

  logic          clk_i, rstn_i;
  logic [N-1:0]  ext_int_i, en_i, edge_mode_i;
  logic [N*PW-1:0] prio_i;
  logic [PW-1:0] threshold_i;
  logic          global_en_i, irq_o, claim_i, complete_i, active_o;
  logic [31:0]   cause_o;
  logic          illegal_instr_i, misalig_acc_i, ecall_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ill;
    logic        mis;
    logic        ecl;
    logic [31:0] expCause;
    logic        expIrq;
  } excVec_t;
  excVec_t excTable[16];

  logic [N-1:0] seenQ[$];
  bit mPend[N];
  bit mWinValid;
  int mWinId;
  bit mActive;
  int mClaimed;

  riscv_intc_plic dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .ext_int_i(ext_int_i), .en_i(en_i),
    .edge_mode_i(edge_mode_i), .prio_i(prio_i), .threshold_i(threshold_i),
    .global_en_i(global_en_i), .irq_o(irq_o), .cause_o(cause_o),
    .claim_i(claim_i), .complete_i(complete_i), .active_o(active_o),
    .illegal_instr_i(illegal_instr_i), .misalig_acc_i(misalig_acc_i), .ecall_i(ecall_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic int prioOf(int i);
    return int'(prio_i[i*PW +: PW]);
  endfunction

  function automatic bit eligible(int i);
    return mPend[i] && en_i[i] && (prioOf(i) > int'(threshold_i))
           && !(mActive && !edge_mode_i[i] && mClaimed == i);
  endfunction

  function automatic bit modelIrq();
    return mWinValid && global_en_i && !mActive;
  endfunction

  function automatic logic [31:0] modelCause();
    if (illegal_instr_i) return 32'd2;
    if (misalig_acc_i)   return 32'd4;
    if (ecall_i)         return 32'd11;
    if (modelIrq())      return BASE + 32'(mWinId);
    if (mActive)         return BASE + 32'(mClaimed);
    return 32'd0;
  endfunction

  task automatic modelReset();
    seenQ.delete();
    repeat (3) seenQ.push_back('0);
    for (int i = 0; i < N; i++) mPend[i] = 1'b0;
    mWinValid = 1'b0;
    mWinId    = 0;
    mActive   = 1'b0;
    mClaimed  = 0;
  endtask

  // seenQ[1]/seenQ[2] are the line values two and three samples back, i.e. what
  // the synchroniser presents to the pending logic at the coming edge.
  task automatic modelStep();
    logic [N-1:0] syncNow, syncOld;
    bit newPend[N];
    int maxP, newId;
    bit fire;
    syncNow = seenQ[1];
    syncOld = seenQ[2];
    fire = claim_i && modelIrq();
    maxP = -1;
    for (int i = 0; i < N; i++)
      if (eligible(i) && prioOf(i) > maxP) maxP = prioOf(i);
    newId = 0;
    for (int i = N - 1; i >= 0; i--)
      if (eligible(i) && prioOf(i) == maxP) newId = i;
    for (int i = 0; i < N; i++) begin
      if (edge_mode_i[i])
        newPend[i] = (mPend[i] && !(fire && mWinId == i)) || (syncNow[i] && !syncOld[i] && en_i[i]);
      else
        newPend[i] = syncNow[i] && en_i[i];
    end
    if (fire) begin
      mActive  = 1'b1;
      mClaimed = mWinId;
    end else if (complete_i && mActive) begin
      mActive = 1'b0;
    end
    mPend     = newPend;
    mWinValid = (maxP >= 0);
    mWinId    = newId;
    seenQ.push_front(ext_int_i);
    void'(seenQ.pop_back());
  endtask

  task automatic stepClock(int n = 1);
    repeat (n) begin
      modelStep();
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic checkOutput(string name, logic expIrq, logic expActive, logic [31:0] expCause);
    checks++;
    if (irq_o !== expIrq) begin
      errors++;
      $display("[TB] FAIL %s irq_o: got %0b want %0b", name, irq_o, expIrq);
    end
    checks++;
    if (active_o !== expActive) begin
      errors++;
      $display("[TB] FAIL %s active_o: got %0b want %0b", name, active_o, expActive);
    end
    checks++;
    if (cause_o !== expCause) begin
      errors++;
      $display("[TB] FAIL %s cause_o: got %h want %h", name, cause_o, expCause);
    end
  endtask

  task automatic clearConfig();
    ext_int_i = '0; en_i = '1; edge_mode_i = '0; prio_i = '0; threshold_i = '0;
    global_en_i = 1'b1; claim_i = 1'b0; complete_i = 1'b0;
    illegal_instr_i = 1'b0; misalig_acc_i = 1'b0; ecall_i = 1'b0;
  endtask

  task automatic resetDut();
    rstn_i = 1'b0;
    #2;
    modelReset();
    rstn_i = 1'b1;
    clearConfig();
  endtask

  task automatic setSrc(int i, bit edgeM, int p);
    edge_mode_i[i] = edgeM;
    prio_i[i*PW +: PW] = PW'(p);
  endtask

  task automatic pulse(logic [N-1:0] mask);
    ext_int_i = ext_int_i | mask;
    stepClock(1);
    ext_int_i = ext_int_i & ~mask;
  endtask

  task automatic claimOnce();
    claim_i = 1'b1;
    stepClock(1);
    claim_i = 1'b0;
  endtask

  task automatic completeOnce();
    complete_i = 1'b1;
    stepClock(1);
    complete_i = 1'b0;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++)
      if ($urandom_range(7) == 0) ext_int_i[i] = ~ext_int_i[i];
    global_en_i     = ($urandom_range(15) != 0);
    claim_i         = ($urandom_range(3) == 0);
    complete_i      = ($urandom_range(4) == 0);
    illegal_instr_i = ($urandom_range(24) == 0);
    misalig_acc_i   = ($urandom_range(24) == 0);
    ecall_i         = ($urandom_range(24) == 0);
    if ($urandom_range(49) == 0) threshold_i = PW'($urandom_range(3));
  endtask

  task automatic runTable(int first, string tag);
    for (int k = first; k < first + 8; k++) begin
      illegal_instr_i = excTable[k].ill;
      misalig_acc_i   = excTable[k].mis;
      ecall_i         = excTable[k].ecl;
      stepClock(1);
      checkOutput($sformatf("%s%0d", tag, k), excTable[k].expIrq, 1'b0, excTable[k].expCause);
    end
    illegal_instr_i = 1'b0; misalig_acc_i = 1'b0; ecall_i = 1'b0;
  endtask

  initial begin
    excTable[0]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    excTable[1]  = '{1'b0, 1'b0, 1'b1, 32'd11, 1'b0};
    excTable[2]  = '{1'b0, 1'b1, 1'b0, 32'd4, 1'b0};
    excTable[3]  = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b0};
    excTable[4]  = '{1'b1, 1'b0, 1'b0, 32'd2, 1'b0};
    excTable[5]  = '{1'b1, 1'b0, 1'b1, 32'd2, 1'b0};
    excTable[6]  = '{1'b1, 1'b1, 1'b0, 32'd2, 1'b0};
    excTable[7]  = '{1'b1, 1'b1, 1'b1, 32'd2, 1'b0};
    excTable[8]  = '{1'b0, 1'b0, 1'b0, 32'h80000014, 1'b1};
    excTable[9]  = '{1'b0, 1'b0, 1'b1, 32'd11, 1'b1};
    excTable[10] = '{1'b0, 1'b1, 1'b0, 32'd4, 1'b1};
    excTable[11] = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b1};
    excTable[12] = '{1'b1, 1'b0, 1'b0, 32'd2, 1'b1};
    excTable[13] = '{1'b1, 1'b0, 1'b1, 32'd2, 1'b1};
    excTable[14] = '{1'b1, 1'b1, 1'b0, 32'd2, 1'b1};
    excTable[15] = '{1'b1, 1'b1, 1'b1, 32'd2, 1'b1};

    clearConfig();
    rstn_i = 1'b0;
    modelReset();
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    checkOutput("reset", 1'b0, 1'b0, 32'd0);
    runTable(0, "excIdle");

    $display("[TB] edge source 5 claim/complete");
    setSrc(5, 1'b1, 3);
    pulse(N'(1) << 5);
    stepClock(2);
    checkOutput("edge5_latency3", 1'b0, 1'b0, 32'd0);
    stepClock(1);
    checkOutput("edge5_raise", 1'b1, 1'b0, 32'h80000015);
    claimOnce();
    checkOutput("edge5_claim", 1'b0, 1'b1, 32'h80000015);
    stepClock(1);
    checkOutput("edge5_service", 1'b0, 1'b1, 32'h80000015);
    completeOnce();
    checkOutput("edge5_complete", 1'b0, 1'b0, 32'd0);
    stepClock(3);
    checkOutput("edge5_noReraise", 1'b0, 1'b0, 32'd0);

    $display("[TB] priority and tie-break");
    resetDut();
    setSrc(2, 1'b1, 4);
    setSrc(7, 1'b1, 6);
    pulse((N'(1) << 2) | (N'(1) << 7));
    stepClock(3);
    checkOutput("prio_7wins", 1'b1, 1'b0, 32'h80000017);
    claimOnce();
    checkOutput("prio_claim7", 1'b0, 1'b1, 32'h80000017);
    stepClock(1);
    completeOnce();
    checkOutput("prio_then2", 1'b1, 1'b0, 32'h80000012);
    claimOnce();
    stepClock(1);
    completeOnce();
    checkOutput("prio_drained", 1'b0, 1'b0, 32'd0);
    setSrc(3, 1'b1, 5);
    setSrc(9, 1'b1, 5);
    pulse((N'(1) << 3) | (N'(1) << 9));
    stepClock(3);
    checkOutput("tie_3wins", 1'b1, 1'b0, 32'h80000013);
    claimOnce();
    stepClock(1);
    completeOnce();
    checkOutput("tie_then9", 1'b1, 1'b0, 32'h80000019);
    claimOnce();
    stepClock(1);
    completeOnce();
    checkOutput("tie_drained", 1'b0, 1'b0, 32'd0);

    $display("[TB] threshold");
    resetDut();
    threshold_i = 3'd4;
    setSrc(1, 1'b1, 4);
    pulse(N'(1) << 1);
    stepClock(5);
    checkOutput("thr_blocked", 1'b0, 1'b0, 32'd0);
    threshold_i = 3'd3;
    stepClock(1);
    checkOutput("thr_lowered", 1'b1, 1'b0, 32'h80000011);

    $display("[TB] level source 0");
    resetDut();
    setSrc(0, 1'b0, 2);
    ext_int_i[0] = 1'b1;
    stepClock(3);
    checkOutput("lvl_latency3", 1'b0, 1'b0, 32'd0);
    stepClock(1);
    checkOutput("lvl_raise", 1'b1, 1'b0, 32'h80000010);
    claimOnce();
    checkOutput("lvl_claim", 1'b0, 1'b1, 32'h80000010);
    stepClock(2);
    checkOutput("lvl_service", 1'b0, 1'b1, 32'h80000010);
    completeOnce();
    checkOutput("lvl_complete", 1'b0, 1'b0, 32'd0);
    stepClock(1);
    checkOutput("lvl_reraise", 1'b1, 1'b0, 32'h80000010);
    ext_int_i[0] = 1'b0;
    stepClock(3);
    checkOutput("lvl_dropPending", 1'b1, 1'b0, 32'h80000010);
    stepClock(1);
    checkOutput("lvl_dropped", 1'b0, 1'b0, 32'd0);
    claimOnce();
    checkOutput("lvl_claimIgnored", 1'b0, 1'b0, 32'd0);

    $display("[TB] edge while active, global enable, exceptions, async reset");
    resetDut();
    setSrc(4, 1'b1, 3);
    pulse(N'(1) << 4);
    stepClock(3);
    checkOutput("act4_raise", 1'b1, 1'b0, 32'h80000014);
    claimOnce();
    checkOutput("act4_claim", 1'b0, 1'b1, 32'h80000014);
    pulse(N'(1) << 4);
    stepClock(3);
    checkOutput("act4_heldPending", 1'b0, 1'b1, 32'h80000014);
    completeOnce();
    checkOutput("act4_reraise", 1'b1, 1'b0, 32'h80000014);
    claimOnce();
    stepClock(1);
    completeOnce();
    checkOutput("act4_drained", 1'b0, 1'b0, 32'd0);
    global_en_i = 1'b0;
    pulse(N'(1) << 4);
    stepClock(5);
    checkOutput("gen_masked", 1'b0, 1'b0, 32'd0);
    global_en_i = 1'b1;
    #1;
    checkOutput("gen_unmasked", 1'b1, 1'b0, 32'h80000014);
    runTable(8, "excIrq");
    claimOnce();
    checkOutput("rst_claim", 1'b0, 1'b1, 32'h80000014);
    setSrc(6, 1'b1, 5);
    pulse(N'(1) << 6);
    stepClock(3);
    checkOutput("rst_pending6", 1'b0, 1'b1, 32'h80000014);
    rstn_i = 1'b0;
    #1;
    checkOutput("rst_async", 1'b0, 1'b0, 32'd0);
    modelReset();
    #1;
    rstn_i = 1'b1;
    stepClock(5);
    checkOutput("rst_pendingLost", 1'b0, 1'b0, 32'd0);

    $display("[TB] randomized traffic");
    resetDut();
    for (int seg = 0; seg < 10; seg++) begin
      en_i        = N'($urandom);
      edge_mode_i = N'($urandom);
      prio_i      = (N*PW)'({$urandom, $urandom});
      threshold_i = PW'($urandom_range(3));
      for (int c = 0; c < 200; c++) begin
        applyStimulus();
        stepClock(1);
        checkOutput($sformatf("rand%0d_%0d", seg, c), modelIrq(), mActive, modelCause());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
